// File: rtl/acc_responder.sv
// Accelerator-side endpoint of the offload interface: dispatches matching requests in order
// and returns id-tagged results. Define ACC_RESPONDER_ADDR_CHECK_EN to enable address checking.
module acc_responder #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 4,
    parameter int unsigned IdWidth        = 5,
    parameter int unsigned AccAddr        = 0,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 q_valid_i,
    output logic                 q_ready_o,
    input  logic [AddrWidth-1:0] q_addr_i,
    input  logic [31:0]          q_data_op_i,
    input  logic [DataWidth-1:0] q_data_arga_i,
    input  logic [DataWidth-1:0] q_data_argb_i,
    input  logic [DataWidth-1:0] q_data_argc_i,
    input  logic [IdWidth-1:0]   q_id_i,
    output logic                 exe_valid_o,
    input  logic                 exe_ready_i,
    output logic [31:0]          exe_op_o,
    output logic [DataWidth-1:0] exe_arga_o,
    output logic [DataWidth-1:0] exe_argb_o,
    output logic [DataWidth-1:0] exe_argc_o,
    input  logic                 exe_rsp_valid_i,
    output logic                 exe_rsp_ready_o,
    input  logic [DataWidth-1:0] exe_rsp_data_i,
    input  logic                 exe_rsp_wb_i,
    output logic                 p_valid_o,
    input  logic                 p_ready_i,
    output logic [DataWidth-1:0] p_data_o,
    output logic [IdWidth-1:0]   p_id_o,
    output logic                 p_error_o
);
    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [PtrWidth-1:0] LastPtr   = PtrWidth'(MaxOutstanding - 1);
    localparam logic [CntWidth-1:0] FullCount = CntWidth'(MaxOutstanding);

    logic [IdWidth-1:0]  tags [MaxOutstanding];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                addr_match;
    logic                running;
    logic                push;
    logic                pop;
    logic                rsp_load;
    logic [IdWidth-1:0]  head_id;

`ifdef ACC_RESPONDER_ADDR_CHECK_EN
    typedef enum logic {RUN, DRAIN} state_t;

    state_t             state;
    logic [IdWidth-1:0] err_id;
    logic               err_accept;
    logic               err_load;

    assign addr_match = (q_addr_i == AddrWidth'(AccAddr));
    assign running    = (state == RUN);
    assign err_accept = !rst_i && running && !addr_match && q_valid_i;
    // The error response waits until every earlier response has left, keeping issue order.
    assign err_load   = !running && fifo_empty && !p_valid_o;
`else
    logic [AddrWidth-1:0] unused_addr;

    assign unused_addr = q_addr_i ^ AddrWidth'(AccAddr);
    assign addr_match  = 1'b1;
    assign running     = 1'b1;
    assign p_error_o   = 1'b0;
`endif

    assign fifo_full  = (count == FullCount);
    assign fifo_empty = (count == '0);
    assign head_id    = tags[rd_ptr];

    assign exe_op_o   = q_data_op_i;
    assign exe_arga_o = q_data_arga_i;
    assign exe_argb_o = q_data_argb_i;
    assign exe_argc_o = q_data_argc_i;

    assign exe_valid_o     = !rst_i && running && addr_match && q_valid_i && !fifo_full;
    assign q_ready_o       = !rst_i && running && (addr_match ? (exe_ready_i && !fifo_full) : 1'b1);
    assign exe_rsp_ready_o = !rst_i && (!p_valid_o || p_ready_i);

    assign push     = exe_valid_o && exe_ready_i;
    assign pop      = exe_rsp_valid_i && exe_rsp_ready_o && !fifo_empty;
    assign rsp_load = pop && exe_rsp_wb_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            tags[wr_ptr] <= q_id_i;
        end
    end

    // Pointers wrap at MaxOutstanding, which need not be a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_valid_o <= 1'b0;
            p_data_o  <= '0;
            p_id_o    <= '0;
`ifdef ACC_RESPONDER_ADDR_CHECK_EN
            p_error_o <= 1'b0;
            state     <= RUN;
            err_id    <= '0;
`endif
        end else begin
            if (rsp_load) begin
                p_valid_o <= 1'b1;
                p_data_o  <= exe_rsp_data_i;
                p_id_o    <= head_id;
`ifdef ACC_RESPONDER_ADDR_CHECK_EN
                p_error_o <= 1'b0;
            end else if (err_load) begin
                p_valid_o <= 1'b1;
                p_data_o  <= '0;
                p_id_o    <= err_id;
                p_error_o <= 1'b1;
`endif
            end else if (p_valid_o && p_ready_i) begin
                p_valid_o <= 1'b0;
            end
`ifdef ACC_RESPONDER_ADDR_CHECK_EN
            if (err_load) begin
                state <= RUN;
            end else if (err_accept) begin
                state  <= DRAIN;
                err_id <= q_id_i;
            end
`endif
        end
    end

`ifndef SYNTHESIS
    rsp_needs_tag: assert property (@(posedge clk_i) disable iff (rst_i)
        (exe_rsp_valid_i && exe_rsp_ready_o) |-> !fifo_empty);
`endif

endmodule
